nyancat_capture: RTL

NYANCAT_CAPTURE -- requirements
Module: nyancat_capture

---
 rtl/nyancat_capture_if.sv | 34 +++
 rtl/nyancat_capture.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/nyancat_capture_if.sv
// Signal bundle for nyancat_capture: video input, control handshake,
// palette write port, capture readback and status outputs.
// master: the driving side (video source / host); slave: the capture block.
interface nyancat_capture_if #(
  parameter int unsigned X_COORD_WIDTH = 10,
  parameter int unsigned Y_COORD_WIDTH = 10
) ();
  logic [X_COORD_WIDTH-1:0] x_px;
  logic [Y_COORD_WIDTH-1:0] y_px;
  logic                     activevideo;
  logic [5:0]               rrggbb;
  logic                     start;
  logic                     busy;
  logic                     done;
  logic                     pal_we;
  logic [3:0]               pal_addr;
  logic [5:0]               pal_wdata;
  logic [11:0]              rd_addr;
  logic [3:0]               rd_data;
  logic [11:0]              unmatched_cnt;
  logic [15:0]              crc;

  modport master (
    output x_px, y_px, activevideo, rrggbb, start,
    output pal_we, pal_addr, pal_wdata, rd_addr,
    input  busy, done, rd_data, unmatched_cnt, crc
  );

  modport slave (
    input  x_px, y_px, activevideo, rrggbb, start,
    input  pal_we, pal_addr, pal_wdata, rd_addr,
    output busy, done, rd_data, unmatched_cnt, crc
  );
endinterface

// File: rtl/nyancat_capture.sv
// nyancat_capture: samples a 64x64 grid out of the active video area
// (step SCALE = V_ACTIVE/64, horizontally centred), reverse-maps each sampled
// 2R2G2B pixel through a 16-entry palette and stores the 4-bit index in a
// 4096x4 capture RAM readable through a registered port.
// Optional: define NYANCAT_CAPTURE_CRC_EN for a CRC-16/CCITT over the
// captured indices; otherwise crc reads as zero.
module nyancat_capture #(
  parameter int unsigned H_ACTIVE      = 640,
  parameter int unsigned V_ACTIVE      = 480,
  parameter int unsigned X_COORD_WIDTH = 10,
  parameter int unsigned Y_COORD_WIDTH = 10,
  parameter int unsigned PIPE_LAT      = 2
) (
  input  logic              px_clk,
  input  logic              reset,
  nyancat_capture_if.slave  bus
);

  localparam int unsigned SCALE    = V_ACTIVE / 64;
  localparam int unsigned SPAN     = 64 * SCALE;
  localparam int unsigned OFFSET_X = (H_ACTIVE - SPAN) / 2;

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

  state_t state, state_n;

  logic [X_COORD_WIDTH-1:0] x_d [PIPE_LAT];
  logic [Y_COORD_WIDTH-1:0] y_d [PIPE_LAT];
  logic [PIPE_LAT-1:0]      av_d;

  logic [X_COORD_WIDTH-1:0] dx;
  logic [Y_COORD_WIDTH-1:0] dy;
  logic                     dav;
  logic [31:0]              dx32, dy32, rel_x;
  logic                     sample_pt, frame_start;
  logic [11:0]              cap_addr;

  logic [5:0]  pal_mem [16];
  logic [3:0]  cap_mem [4096];
  logic [3:0]  pal_idx;
  logic        pal_hit;
  logic [3:0]  rd_q;

  logic        cap_en, cap_we, clear, busy, done;
  logic [11:0] sample_cnt, unmatched_q;

  // Align coordinates and active flag with the pixel colour pipeline
  always_ff @(posedge px_clk) begin
    x_d[0] <= bus.x_px;
    y_d[0] <= bus.y_px;
    for (int unsigned i = 1; i < PIPE_LAT; i++) begin
      x_d[i] <= x_d[i-1];
      y_d[i] <= y_d[i-1];
    end
    if (reset) begin
      av_d <= '0;
    end else begin
      av_d[0] <= bus.activevideo;
      for (int unsigned i = 1; i < PIPE_LAT; i++) av_d[i] <= av_d[i-1];
    end
  end

  assign dx  = x_d[PIPE_LAT-1];
  assign dy  = y_d[PIPE_LAT-1];
  assign dav = av_d[PIPE_LAT-1];

  // Sample-grid decode and capture address from delayed coordinates
  always_comb begin
    dx32        = 32'(dx);
    dy32        = 32'(dy);
    rel_x       = dx32 - OFFSET_X;
    sample_pt   = dav && (dx32 >= OFFSET_X) && (dx32 < OFFSET_X + SPAN) &&
                  (dy32 < SPAN) && (rel_x % SCALE == 0) && (dy32 % SCALE == 0);
    cap_addr    = 12'((dy32 / SCALE) * 64 + rel_x / SCALE);
    frame_start = dav && (dx == '0) && (dy == '0);
  end

  // Reverse palette lookup; scanning downward leaves the lowest matching index
  always_comb begin
    pal_idx = '1;
    pal_hit = 1'b0;
    for (int unsigned i = 16; i > 0; i--) begin
      if (pal_mem[i-1] == bus.rrggbb) begin
        pal_idx = 4'(i - 1);
        pal_hit = 1'b1;
      end
    end
  end

  // Palette RAM, writable in every state and not touched by reset
  always_ff @(posedge px_clk) begin
    if (bus.pal_we) pal_mem[bus.pal_addr] <= bus.pal_wdata;
  end

  // Capture RAM with registered read-before-write readback
  always_ff @(posedge px_clk) begin
    if (cap_we) cap_mem[cap_addr] <= pal_idx;
    rd_q <= cap_mem[bus.rd_addr];
  end

  // FSM state register
  always_ff @(posedge px_clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // FSM next state and outputs; the arming pixel itself follows capture rules
  always_comb begin
    state_n = state;
    clear   = 1'b0;
    cap_en  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_n = ARMED;
          clear   = 1'b1;
        end
      end
      ARMED: begin
        busy = 1'b1;
        if (frame_start) begin
          state_n = CAPTURE;
          cap_en  = 1'b1;
        end
      end
      CAPTURE: begin
        busy   = 1'b1;
        cap_en = 1'b1;
        if (sample_pt && (sample_cnt == '1)) state_n = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (bus.start) begin
          state_n = ARMED;
          clear   = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    cap_we = cap_en && sample_pt;
  end

  // Sample and saturating unmatched-pixel counters
  always_ff @(posedge px_clk) begin
    if (reset || clear) begin
      sample_cnt  <= '0;
      unmatched_q <= '0;
    end else if (cap_we) begin
      sample_cnt <= sample_cnt + 12'd1;
      if (!pal_hit && (unmatched_q != '1)) unmatched_q <= unmatched_q + 12'd1;
    end
  end

`ifdef NYANCAT_CAPTURE_CRC_EN
  logic [15:0] crc_q;

  function automatic logic [15:0] crc_nibble(input logic [15:0] c_in, input logic [3:0] nib);
    logic [15:0] c;
    c = c_in;
    for (int unsigned b = 4; b > 0; b--) begin
      if (c[15] ^ nib[b-1]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else                  c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  // CRC over each written index, seeded when a capture is armed
  always_ff @(posedge px_clk) begin
    if (reset)       crc_q <= '0;
    else if (clear)  crc_q <= '1;
    else if (cap_we) crc_q <= crc_nibble(crc_q, pal_idx);
  end

  assign bus.crc = crc_q;
`else
  assign bus.crc = '0;
`endif

  assign bus.busy          = busy;
  assign bus.done          = done;
  assign bus.rd_data       = rd_q;
  assign bus.unmatched_cnt = unmatched_q;

endmodule
